// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: display reads the front bank, the host writes the back bank,
// and the banks swap only on frame_complete. Optional macro DISPLAY_FRAMEBUFFER_COPY_EN adds a post-swap front->back copy.
module display_framebuffer #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int RW = (rows > 1) ? $clog2(rows) : 1,
  localparam int CW = (columns > 1) ? $clog2(columns) : 1,
  localparam int SW = (segments > 1) ? $clog2(segments) : 1,
  localparam int PW = 3 * bitwidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RW-1:0]          row,
  input  logic [CW-1:0]          column,
  output logic [segments*PW-1:0] pixel,
  input  logic                   frame_complete,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SW-1:0]          wr_segment,
  input  logic [RW-1:0]          wr_row,
  input  logic [CW-1:0]          wr_column,
  input  logic [PW-1:0]          wr_data,
  input  logic                   swap_req,
  output logic                   swap_pending,
  output logic                   swap_done,
  output logic                   front_sel
);

  localparam int AW    = SW + RW + CW;
  localparam int DEPTH = 2 ** (AW + 1);
  localparam logic [SW:0] SEG_LIM = (SW+1)'(segments);
  localparam logic [RW:0] ROW_LIM = (RW+1)'(rows);
  localparam logic [CW:0] COL_LIM = (CW+1)'(columns);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } state_t;

  logic [PW-1:0]          mem_r [DEPTH];
  state_t                 state_r;
  state_t                 state_next_s;
  logic                   front_sel_r;
  logic                   pending_r;
  logic                   done_r;
  logic                   ready_r;
  logic [segments*PW-1:0] pixel_r;
  logic                   swap_now_s;
  logic                   done_set_s;
  logic                   wr_hit_s;

  // Bank index lives in the MSB so each bank is a contiguous half of the array.
  function automatic logic [AW:0] mem_idx(input logic bank, input logic [SW-1:0] seg,
                                          input logic [RW-1:0] r, input logic [CW-1:0] c);
    return {bank, seg, r, c};
  endfunction

  function automatic logic in_range(input logic [SW-1:0] seg, input logic [RW-1:0] r,
                                    input logic [CW-1:0] c);
    return ({1'b0, seg} < SEG_LIM) && ({1'b0, r} < ROW_LIM) && ({1'b0, c} < COL_LIM);
  endfunction

  assign wr_hit_s = wr_valid && ready_r && !rst && in_range(wr_segment, wr_row, wr_column);

`ifdef DISPLAY_FRAMEBUFFER_COPY_EN
  localparam logic [SW-1:0] SEG_LAST = SW'(segments - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);

  logic [SW-1:0] copy_seg_r;
  logic [RW-1:0] copy_row_r;
  logic [CW-1:0] copy_col_r;
  logic          copy_last_s;
  logic          copy_active_s;

  assign copy_last_s   = (copy_seg_r == SEG_LAST) && (copy_row_r == ROW_LAST) &&
                         (copy_col_r == COL_LAST);
  assign copy_active_s = (state_r == ST_COPY) && !rst;

  // Copy address walks column fastest, then row, then segment.
  always_ff @(posedge clk) begin
    if (rst || swap_now_s) begin
      copy_seg_r <= '0;
      copy_row_r <= '0;
      copy_col_r <= '0;
    end else if (state_r == ST_COPY) begin
      if (copy_col_r == COL_LAST) begin
        copy_col_r <= '0;
        if (copy_row_r == ROW_LAST) begin
          copy_row_r <= '0;
          copy_seg_r <= copy_seg_r + SW'(1);
        end else begin
          copy_row_r <= copy_row_r + RW'(1);
        end
      end else begin
        copy_col_r <= copy_col_r + CW'(1);
      end
    end
  end

  // Memory write port: host writes or the front->back copy (never both, host is stalled).
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      mem_r[mem_idx(~front_sel_r, wr_segment, wr_row, wr_column)] <= wr_data;
    end else if (copy_active_s) begin
      mem_r[mem_idx(~front_sel_r, copy_seg_r, copy_row_r, copy_col_r)] <=
        mem_r[mem_idx(front_sel_r, copy_seg_r, copy_row_r, copy_col_r)];
    end
  end
`else
  // Memory write port: host writes always target the back bank.
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      mem_r[mem_idx(~front_sel_r, wr_segment, wr_row, wr_column)] <= wr_data;
    end
  end
`endif

  // Display read port: one registered word per segment from the front bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_r <= '0;
    end else begin
      for (int s = 0; s < segments; s++) begin
        if (in_range(SW'(s), row, column)) begin
          pixel_r[s*PW +: PW] <= mem_r[mem_idx(front_sel_r, SW'(s), row, column)];
        end else begin
          pixel_r[s*PW +: PW] <= '0;
        end
      end
    end
  end

  // Next-state logic; a swap_req seen in the same cycle as frame_complete only arms PENDING.
  always_comb begin
    state_next_s = state_r;
    swap_now_s   = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (swap_req) state_next_s = ST_PENDING;
        else          state_next_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (frame_complete) begin
          swap_now_s = 1'b1;
`ifdef DISPLAY_FRAMEBUFFER_COPY_EN
          state_next_s = ST_COPY;
`else
          state_next_s = ST_IDLE;
          done_set_s   = 1'b1;
`endif
        end else begin
          state_next_s = ST_PENDING;
        end
      end
`ifdef DISPLAY_FRAMEBUFFER_COPY_EN
      ST_COPY: begin
        if (copy_last_s) begin
          state_next_s = ST_IDLE;
          done_set_s   = 1'b1;
        end else begin
          state_next_s = ST_COPY;
        end
      end
`endif
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      front_sel_r <= 1'b0;
      pending_r   <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      front_sel_r <= swap_now_s ? ~front_sel_r : front_sel_r;
      pending_r   <= (state_next_s == ST_PENDING);
      done_r      <= done_set_s;
      ready_r     <= (state_next_s == ST_IDLE);
    end
  end

  assign pixel        = pixel_r;
  assign wr_ready     = ready_r;
  assign swap_pending = pending_r;
  assign swap_done    = done_r;
  assign front_sel    = front_sel_r;

endmodule

// File: tb/tb_display_framebuffer.sv
// Randomized scoreboard bench for display_framebuffer against a bank-array reference model.
module tb_display_framebuffer;

  localparam int ROWS  = 8;
  localparam int COLS  = 32;
  localparam int NWORD = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst, frame_complete, wr_valid, swap_req;
  logic [2:0]  row, wr_row;
  logic [4:0]  column, wr_column;
  logic [0:0]  wr_segment;
  logic [23:0] wr_data;
  logic [23:0] pixel;
  logic        wr_ready, swap_pending, swap_done, front_sel;

  always #5 clk = ~clk;

  display_framebuffer #(.segments(1), .rows(ROWS), .columns(COLS), .bitwidth(8)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .pixel(pixel),
    .frame_complete(frame_complete), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_segment(wr_segment), .wr_row(wr_row), .wr_column(wr_column), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_sel(front_sel)
  );

  typedef struct {
    logic [23:0] pix;
    bit          pix_chk;
    bit          fs, pend, done, rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: two banks indexed [bank][row][col]; mode 0=idle 1=pending 2=copying
  logic [23:0] m_bank  [2][ROWS][COLS];
  bit          m_known [2][ROWS][COLS];
  bit          m_front = 1'b0;
  int          m_mode  = 0;
  int          m_left  = 0;
  bit          m_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One clock: predict this edge's outcome from current inputs, then advance.
  task automatic tick();
    exp_t e;
    bit   rdy_now;
    rdy_now = (m_mode == 0);
    if (rst) begin
      if (m_mode == 2) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) m_known[!m_front][r][c] = 1'b0;
      end
      e.pix = 24'h000000; e.pix_chk = 1'b1;
      m_front = 1'b0; m_mode = 0; m_done = 1'b0;
    end else begin
      e.pix     = m_bank[m_front][row][column];
      e.pix_chk = m_known[m_front][row][column];
      if (wr_valid && rdy_now && wr_segment == 1'b0) begin
        m_bank[!m_front][wr_row][wr_column]  = wr_data;
        m_known[!m_front][wr_row][wr_column] = 1'b1;
      end
      m_done = 1'b0;
      case (m_mode)
        0: if (swap_req) m_mode = 1;
        1: if (frame_complete) begin
          m_front = !m_front;
`ifdef DISPLAY_FRAMEBUFFER_COPY_EN
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
              m_bank[!m_front][r][c]  = m_bank[m_front][r][c];
              m_known[!m_front][r][c] = m_known[m_front][r][c];
            end
          m_mode = 2;
          m_left = NWORD;
`else
          m_mode = 0;
          m_done = 1'b1;
`endif
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 0;
            m_done = 1'b1;
          end
        end
        default: m_mode = 0;
      endcase
    end
    e.fs = m_front; e.pend = (m_mode == 1); e.done = m_done; e.rdy = (m_mode == 0);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every edge presents a registered result; compare against the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.pix_chk) check("pixel", {8'h00, pixel}, {8'h00, e.pix});
      check("front_sel", {31'd0, front_sel}, {31'd0, e.fs});
      check("swap_pending", {31'd0, swap_pending}, {31'd0, e.pend});
      check("swap_done", {31'd0, swap_done}, {31'd0, e.done});
      check("wr_ready", {31'd0, wr_ready}, {31'd0, e.rdy});
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; frame_complete = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
    wr_segment = 1'b0; wr_row = 3'd0; wr_column = 5'd0; wr_data = 24'h000000;
    row = 3'($urandom_range(0, ROWS - 1)); column = 5'($urandom_range(0, COLS - 1));
  endtask

  task automatic swap_and_settle();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (3) tick();
    frame_complete = 1'b1; tick(); frame_complete = 1'b0;
    repeat (NWORD + 4) tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    row = 3'd0; column = 5'd0;
    repeat (2) tick();
    rst = 1'b0;

    // Fill back bank, present it, fill the other bank so every word is known
    for (int pass = 0; pass < 2; pass++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          wr_valid = 1'b1; wr_segment = 1'b0; wr_row = 3'(r); wr_column = 5'(c);
          wr_data = 24'($urandom);
          row = 3'($urandom_range(0, ROWS - 1)); column = 5'($urandom_range(0, COLS - 1));
          tick();
        end
      wr_valid = 1'b0;
      swap_and_settle();
    end

    // Back-bank write does not disturb the displayed pixel
    idle_inputs();
    wr_valid = 1'b1; wr_row = 3'd0; wr_column = 5'd0; wr_data = 24'hff0000;
    row = 3'd0; column = 5'd0;
    tick();
    wr_valid = 1'b0;
    repeat (2) tick();

    // Swap after a 5-cycle wait, reading (0,0) across the flip
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (5) tick();
    frame_complete = 1'b1; tick(); frame_complete = 1'b0;
    repeat (4) tick();
    repeat (NWORD + 4) tick();

    // Writes stall while pending and land right after the swap/copy
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    wr_valid = 1'b1; wr_row = 3'd1; wr_column = 5'd31; wr_data = 24'h00ff00;
    repeat (10) tick();
    frame_complete = 1'b1; tick(); frame_complete = 1'b0;
    repeat (NWORD + 4) tick();
    wr_valid = 1'b0;

    // swap_req coincident with frame_complete only arms the swap
    swap_req = 1'b1; frame_complete = 1'b1; tick();
    swap_req = 1'b0; frame_complete = 1'b0;
    repeat (3) tick();
    frame_complete = 1'b1; tick(); frame_complete = 1'b0;
    repeat (NWORD + 4) tick();

    // Reset while pending drops the request
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic including discarded segment-1 writes and rare resets
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      swap_req       = ($urandom_range(0, 39) == 0);
      frame_complete = ($urandom_range(0, 24) == 0);
      wr_valid       = $urandom_range(0, 1) == 1;
      wr_segment     = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      wr_row         = 3'($urandom_range(0, ROWS - 1));
      wr_column      = 5'($urandom_range(0, COLS - 1));
      wr_data        = 24'($urandom);
      row            = 3'($urandom_range(0, ROWS - 1));
      column         = 5'($urandom_range(0, COLS - 1));
      tick();
    end

    idle_inputs();
    repeat (2) tick();
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_framebuffer.md
Name: display_framebuffer

Overview:
Double-buffered pixel store directly upstream of display_driver. Serves display_driver's row/column fetch with a registered pixel one cycle later, and accepts host writes into the back buffer. Swaps front/back only on display_driver's frame_complete pulse, so no tearing occurs.

Parameters:
segments, 1, panel segments scanned in parallel; the read port returns one pixel per segment.
rows, 8, rows per segment (matches display_driver rows).
columns, 32, columns per row.
bitwidth, 8, bits per colour channel; pixel word = 3*bitwidth, {R,G,B} MSB-first.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
row  in  clog2(rows)  read row address from display_driver.
column  in  clog2(columns)  read column address from display_driver.
pixel  out  segments*3*bitwidth  front-buffer data; segment 0 in the LSBs.
frame_complete  in  1  one-cycle safe-flip pulse from display_driver.
wr_valid  in  1  host write request.
wr_ready  out  1  write accepted when wr_valid && wr_ready.
wr_segment  in  max(1,clog2(segments))  write segment index.
wr_row  in  clog2(rows)  write row.
wr_column  in  clog2(columns)  write column.
wr_data  in  3*bitwidth  write pixel.
swap_req  in  1  one-cycle request to present the back buffer.
swap_pending  out  1  swap requested, waiting for frame_complete.
swap_done  out  1  one-cycle pulse, the cycle after the swap takes effect.
front_sel  out  1  index of the bank currently displayed.

Behaviour:
- Reset: front_sel=0, swap_pending=0, swap_done=0, wr_ready=1, pixel=0. Memory contents are not reset.
- Read: pixel is registered. It reflects bank[front_sel] at {row,column} sampled on the previous clk edge, so latency is exactly 1 cycle.
- Read with out-of-range row or column (non-power-of-2 sizes): pixel=0 for that fetch.
- Write: on wr_valid && wr_ready, store wr_data into bank[!front_sel] at {wr_segment,wr_row,wr_column}.
  - Out-of-range address: the write is accepted and discarded.
  - Writes never alter the front bank.
- State machine, IDLE/PENDING (plus COPY with the optional feature):
  - IDLE: wr_ready=1. swap_req moves to PENDING, and swap_pending=1 from the next cycle.
  - PENDING: wr_ready=0, so host writes stall. On frame_complete:
    - front_sel toggles on that edge;
    - swap_pending clears;
    - swap_done=1 for the following cycle;
    - next state is IDLE.
- Pixel fetches are addressed against front_sel as of the fetch edge. The fetch sampled on the frame_complete edge still returns the old bank; the next fetch returns the new bank.
- Simultaneous events:
  - swap_req in the same cycle as an accepted write: the write lands in the old back bank, which is the bank that will be presented.
  - swap_req and frame_complete in the same cycle while IDLE: the request is latched only. The swap waits for the next frame_complete.
  - swap_req while PENDING: ignored, no queueing.
  - frame_complete while IDLE: no effect.
- Reset mid-PENDING: request dropped, front_sel=0, wr_ready=1 next cycle.

Optional Feature:
Macro DISPLAY_FRAMEBUFFER_COPY_EN.
- Defined: after each swap, state COPY runs for segments*rows*columns cycles.
  - It copies the new front bank into the new back bank, one word per cycle, in ascending address order.
  - wr_ready=0 for the whole copy. swap_done pulses the cycle after the copy completes, not after the swap.
  - swap_req during COPY is ignored.
  - Display reads are unaffected; this needs a second read port on the front bank.
  - Reset aborts the copy.
- Undefined: no COPY state. The back bank keeps stale contents after a swap, and swap_done follows the swap directly.

Test Plan:
1. Reset, then drive row=0/column=0 -> pixel=0 one cycle later; wr_ready=1, front_sel=0, swap_pending=0.
2. Write 24'hff0000 to (0,0,0), then read (0,0) -> pixel still shows the front-bank value, since bank 0 is untouched.
3. swap_req, wait 5 cycles, pulse frame_complete -> front_sel=1 on that edge; swap_done high exactly the next cycle; read of (0,0) two cycles after frame_complete returns 24'hff0000.
4. While PENDING, hold wr_valid=1 for 10 cycles -> wr_ready=0 throughout; the write is accepted on the first cycle after frame_complete (or after the copy when COPY_EN is set).
5. swap_req coincident with frame_complete while IDLE -> no swap; the next frame_complete swaps. Assert rst during PENDING -> front_sel=0, swap_pending=0, wr_ready=1.
6. COPY_EN, 8x32: write a distinct pattern to back, swap -> wr_ready low for 256 cycles; then all 256 back-bank locations equal front, verified by a swap with no writes showing an identical image.
